multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the LEGv8 datapath: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back over a shared ALU and a single unified memory port. It drives every datapath select and write strobe for the supported subset (ADD, SUB, AND, ORR, LDUR, STUR, CBZ). Memory access uses a ready handshake, so wait states stall the FSM. It sits between the instruction register's opcode field and the existing datapath (PC, IR, register file, sign extender, ALU, ALUOut, MDR).

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  11  IR[31:21], valid from DECODE onward.
- zero  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- reg2loc  out  1  read register 2 select: 0 = Rm, 1 = Rt.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = signext, 11 = signext<<2.
- alu_op  out  2  00 = add, 01 = pass B, 10 = R-type function from op.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Opcode classes:
  - R-type (exact match): 10001011000, 11001011000, 10001010000, 10101010000.
  - LDUR: 11111000010.
  - STUR: 11111000000.
  - CBZ: 10110100???.
  - Anything else is illegal.
- States and outputs. Outputs not listed are 0.
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. When mem_ready: ir_write=1, pc_write=1, pc_src=0; next DECODE. Otherwise stay in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). reg2loc=1 for STUR and CBZ, else 0.
    - R-type → EXEC_R; LDUR or STUR → ADDR; CBZ → BRANCH.
    - Illegal → FETCH, with illegal=1 and instr_done=1.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; → WB_R.
  - WB_R: reg_write=1, mem_to_reg=0, instr_done=1; → FETCH.
  - ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; → MEM_RD if LDUR, MEM_WR if STUR.
  - MEM_RD: mem_req=1, mem_we=0, iord=1. → WB_LD on mem_ready (MDR captures the data), else stay.
  - WB_LD: reg_write=1, mem_to_reg=1, instr_done=1; → FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1, reg2loc=1. On mem_ready: instr_done=1, → FETCH; else stay.
  - BRANCH: reg2loc=1, alu_src_b=00, alu_op=01 (pass Rt).
    - pc_write = zero (Mealy), pc_src=1, instr_done=1.
    - → FETCH unconditionally.
- While a request is pending, mem_req, mem_we and iord are held constant.
- op is sampled combinationally in DECODE, ADDR and BRANCH. The IR is stable because ir_write is asserted only in FETCH.

## Timing
- Reset: every output is 0 during any cycle with reset=1. Reset overrides all transitions, including a mid-wait memory request. The state returns to FETCH, and the first cycle after reset deasserts is FETCH with mem_req=1.
- Latency with mem_ready=1 on the first request cycle:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
  - Illegal: 2 cycles.
- Each wait state adds exactly 1 cycle in FETCH, MEM_RD or MEM_WR.
- mem_ready is ignored in states where mem_req=0.
- pc_write occurs at most once per instruction in FETCH, plus at most once in BRANCH.
- instr_done pulses exactly once per instruction.

## Test plan
- Reset held 3 cycles with mem_ready=1 → all outputs 0. After release, cycle 0 is FETCH with mem_req=1, iord=0.
- ADD (op=10001011000), mem_ready always 1 → ir_write/pc_write at cycle 0, reg_write at cycle 3, instr_done at cycle 3, next FETCH at cycle 4.
- LDUR with mem_ready low for 2 cycles in MEM_RD → mem_req=1, iord=1, mem_we=0 held for 3 cycles. WB_LD asserts reg_write=1 and mem_to_reg=1. Total 7 cycles.
- STUR, mem_ready=1 → MEM_WR at cycle 3 with mem_we=1, reg2loc=1, instr_done=1. reg_write is never asserted.
- CBZ with zero=1, then CBZ with zero=0 → BRANCH cycle has pc_write=1, pc_src=1 only when zero=1. Both take 3 cycles.
- op=00000000000 → illegal=1 and instr_done=1 in DECODE, next FETCH. Separately, reset asserted mid MEM_RD wait → outputs 0, restart at FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control unit: sequences fetch/decode/execute/memory/write-back
// over a shared ALU and a single memory port with a ready handshake.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    WB_LD  = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8
  } state_t;

  localparam logic [2:0] CL_R   = 3'd0;
  localparam logic [2:0] CL_LD  = 3'd1;
  localparam logic [2:0] CL_ST  = 3'd2;
  localparam logic [2:0] CL_CBZ = 3'd3;
  localparam logic [2:0] CL_ILL = 3'd4;

  function automatic logic [2:0] op_class(input logic [10:0] o);
    logic [2:0] c;
    casez (o)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: c = CL_R;
      11'b11111000010:                  c = CL_LD;
      11'b11111000000:                  c = CL_ST;
      11'b10110100???:                  c = CL_CBZ;
      default:                          c = CL_ILL;
    endcase
    return c;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] cls_s;

  assign cls_s = op_class(op);

  // State register; reset wins over every transition, including a pending memory wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Outputs are decoded from state plus the handshake/zero/op terms that must act in the same cycle.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg2loc      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    next_state_s = state_r;
    if (reset) begin
      next_state_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            next_state_s = DECODE;
          end else begin
            next_state_s = FETCH;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          reg2loc   = (cls_s == CL_ST) || (cls_s == CL_CBZ);
          case (cls_s)
            CL_R:         next_state_s = EXEC_R;
            CL_LD, CL_ST: next_state_s = ADDR;
            CL_CBZ:       next_state_s = BRANCH;
            default: begin
              illegal      = 1'b1;
              instr_done   = 1'b1;
              next_state_s = FETCH;
            end
          endcase
        end
        EXEC_R: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          next_state_s = WB_R;
        end
        WB_R: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (cls_s)
            CL_LD:   next_state_s = MEM_RD;
            CL_ST:   next_state_s = MEM_WR;
            default: next_state_s = FETCH;
          endcase
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            next_state_s = WB_LD;
          end else begin
            next_state_s = MEM_RD;
          end
        end
        WB_LD: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          reg2loc = 1'b1;
          if (mem_ready) begin
            instr_done   = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = MEM_WR;
          end
        end
        BRANCH: begin
          // Branch is taken by loading ALUOut (target computed in DECODE) when Rt is zero.
          reg2loc      = 1'b1;
          alu_op       = 2'b01;
          pc_write     = zero;
          pc_src       = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        default: next_state_s = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table for the listed scenarios, then random
// instruction streams checked against a per-instruction cycle-sequence model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] op = 11'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
  logic        mem_to_reg, reg2loc, alu_src_a, instr_done, illegal;
  logic [1:0]  alu_src_b, alu_op;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal)
  );

  // Output vector layout:
  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
  //  reg2loc, alu_src_a, alu_src_b[1:0], alu_op[1:0], instr_done, illegal}
  localparam logic [15:0] ZERO   = 16'h0000;
  localparam logic [15:0] F_W    = 16'h8010;
  localparam logic [15:0] F_R    = 16'h9810;
  localparam logic [15:0] DEC    = 16'h0030;
  localparam logic [15:0] DEC_R2 = 16'h00B0;
  localparam logic [15:0] DEC_IL = 16'h0033;
  localparam logic [15:0] EX_R   = 16'h0048;
  localparam logic [15:0] WB_R   = 16'h0202;
  localparam logic [15:0] ADR    = 16'h0060;
  localparam logic [15:0] MRD    = 16'hA000;
  localparam logic [15:0] WBL    = 16'h0302;
  localparam logic [15:0] MWR_W  = 16'hE080;
  localparam logic [15:0] MWR_R  = 16'hE082;
  localparam logic [15:0] BR_N   = 16'h0486;
  localparam logic [15:0] BR_T   = 16'h0C86;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        z;
    logic [10:0] opv;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  vec_t rq[$];

  function automatic logic [15:0] outs();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
            reg2loc, alu_src_a, alu_src_b, alu_op, instr_done, illegal};
  endfunction

  // 0=R 1=LDUR 2=STUR 3=CBZ 4=illegal
  function automatic int classify(input logic [10:0] o);
    if (o == OP_ADD || o == OP_SUB || o == OP_AND || o == OP_ORR) return 0;
    else if (o == OP_LDUR) return 1;
    else if (o == OP_STUR) return 2;
    else if (o[10:3] == 8'b10110100) return 3;
    else return 4;
  endfunction

  task automatic step(input vec_t v);
    logic [15:0] act;
    @(posedge clk);
    #1;
    reset = v.rst; mem_ready = v.ready; zero = v.z; op = v.opv;
    #1;
    act = outs();
    total_cnt++;
    if (act === v.exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", v.name, act, v.exp, $time);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle sequence of one instruction, from its class, wait counts and zero flag.
  task automatic model_instr(input logic [10:0] o, input int wf, input int wm, input logic z);
    int c = classify(o);
    for (int i = 0; i < wf; i++) rq.push_back('{1'b0, 1'b0, rb(), o, F_W, "fetch_wait"});
    rq.push_back('{1'b0, 1'b1, rb(), o, F_R, "fetch"});
    rq.push_back('{1'b0, rb(), rb(), o, (c == 4) ? DEC_IL : ((c == 2 || c == 3) ? DEC_R2 : DEC), "decode"});
    case (c)
      0: begin
        rq.push_back('{1'b0, rb(), rb(), o, EX_R, "exec_r"});
        rq.push_back('{1'b0, rb(), rb(), o, WB_R, "wb_r"});
      end
      1: begin
        rq.push_back('{1'b0, rb(), rb(), o, ADR, "addr_ld"});
        for (int i = 0; i < wm; i++) rq.push_back('{1'b0, 1'b0, rb(), o, MRD, "mem_rd_wait"});
        rq.push_back('{1'b0, 1'b1, rb(), o, MRD, "mem_rd"});
        rq.push_back('{1'b0, rb(), rb(), o, WBL, "wb_ld"});
      end
      2: begin
        rq.push_back('{1'b0, rb(), rb(), o, ADR, "addr_st"});
        for (int i = 0; i < wm; i++) rq.push_back('{1'b0, 1'b0, rb(), o, MWR_W, "mem_wr_wait"});
        rq.push_back('{1'b0, 1'b1, rb(), o, MWR_R, "mem_wr"});
      end
      3: rq.push_back('{1'b0, rb(), z, o, z ? BR_T : BR_N, "branch"});
      default: ;
    endcase
  endtask

  task automatic add(input logic r, input logic rdy, input logic z, input logic [10:0] o,
                     input logic [15:0] e, input string n);
    tbl.push_back('{r, rdy, z, o, e, n});
  endtask

  initial begin
    logic [10:0] ro;
    int k;
    // Reset held three cycles with mem_ready high.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, OP_ADD, ZERO, "reset");
    // ADD, no waits: 4 cycles then FETCH.
    add(1'b0, 1'b1, 1'b0, OP_ADD, F_R, "add_fetch");
    add(1'b0, 1'b1, 1'b0, OP_ADD, DEC, "add_decode");
    add(1'b0, 1'b1, 1'b0, OP_ADD, EX_R, "add_exec");
    add(1'b0, 1'b1, 1'b0, OP_ADD, WB_R, "add_wb");
    // LDUR, 2 wait cycles in MEM_RD: 7 cycles.
    add(1'b0, 1'b1, 1'b0, OP_LDUR, F_R, "ld_fetch");
    add(1'b0, 1'b0, 1'b0, OP_LDUR, DEC, "ld_decode");
    add(1'b0, 1'b0, 1'b0, OP_LDUR, ADR, "ld_addr");
    add(1'b0, 1'b0, 1'b0, OP_LDUR, MRD, "ld_wait1");
    add(1'b0, 1'b0, 1'b0, OP_LDUR, MRD, "ld_wait2");
    add(1'b0, 1'b1, 1'b0, OP_LDUR, MRD, "ld_mem");
    add(1'b0, 1'b1, 1'b0, OP_LDUR, WBL, "ld_wb");
    // STUR, no waits: 4 cycles.
    add(1'b0, 1'b1, 1'b0, OP_STUR, F_R, "st_fetch");
    add(1'b0, 1'b1, 1'b0, OP_STUR, DEC_R2, "st_decode");
    add(1'b0, 1'b1, 1'b0, OP_STUR, ADR, "st_addr");
    add(1'b0, 1'b1, 1'b0, OP_STUR, MWR_R, "st_mem");
    // CBZ taken, then not taken.
    add(1'b0, 1'b1, 1'b1, OP_CBZ, F_R, "cbz1_fetch");
    add(1'b0, 1'b1, 1'b1, OP_CBZ, DEC_R2, "cbz1_decode");
    add(1'b0, 1'b1, 1'b1, OP_CBZ, BR_T, "cbz1_taken");
    add(1'b0, 1'b1, 1'b0, 11'b10110100111, F_R, "cbz0_fetch");
    add(1'b0, 1'b1, 1'b0, 11'b10110100111, DEC_R2, "cbz0_decode");
    add(1'b0, 1'b1, 1'b0, 11'b10110100111, BR_N, "cbz0_not_taken");
    // Illegal opcode.
    add(1'b0, 1'b1, 1'b0, 11'd0, F_R, "ill_fetch");
    add(1'b0, 1'b1, 1'b0, 11'd0, DEC_IL, "ill_decode");
    // Reset in the middle of a MEM_RD wait.
    add(1'b0, 1'b1, 1'b0, OP_LDUR, F_R, "rst_ld_fetch");
    add(1'b0, 1'b1, 1'b0, OP_LDUR, DEC, "rst_ld_decode");
    add(1'b0, 1'b0, 1'b0, OP_LDUR, ADR, "rst_ld_addr");
    add(1'b0, 1'b0, 1'b0, OP_LDUR, MRD, "rst_ld_wait");
    add(1'b1, 1'b1, 1'b0, OP_LDUR, ZERO, "rst_mid_wait");
    add(1'b0, 1'b0, 1'b0, OP_ADD, F_W, "rst_restart_fetch");
    add(1'b0, 1'b1, 1'b0, OP_ADD, F_R, "rst_restart_fetch2");
    add(1'b0, 1'b1, 1'b0, OP_ADD, DEC, "rst_restart_decode");
    add(1'b0, 1'b1, 1'b0, OP_ADD, EX_R, "rst_restart_exec");
    add(1'b0, 1'b1, 1'b0, OP_ADD, WB_R, "rst_restart_wb");

    foreach (tbl[i]) step(tbl[i]);

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: ro = OP_ADD;
        1: ro = OP_SUB;
        2: ro = OP_AND;
        3: ro = OP_ORR;
        4: ro = OP_LDUR;
        5: ro = OP_STUR;
        6: begin ro = OP_CBZ; ro[2:0] = 3'($urandom_range(0, 7)); end
        default: begin
          ro = 11'($urandom);
          while (classify(ro) != 4) ro = 11'($urandom);
        end
      endcase
      model_instr(ro, $urandom_range(0, 2), $urandom_range(0, 2), rb());
      while (rq.size() > 0) step(rq.pop_front());
    end
    // Last instruction must hand back to FETCH.
    step('{1'b0, 1'b0, 1'b0, OP_ADD, F_W, "final_fetch"});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
